// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the five-stage datapath: walks one instruction
// through Fetch/Decode/Execute/Memory/Write Back and drives the datapath strobes.
module control_sequencer #(
    parameter int unsigned MFC_TIMEOUT = 15,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 Clock,
    input  logic                 ProcessorReset,
    input  logic                 ProcessorEnable,
    input  logic                 Step,
    input  logic                 IsLoad,
    input  logic                 IsStore,
    input  logic                 IsBranch,
    input  logic                 IsJumpReg,
    input  logic                 BranchTaken,
    input  logic                 WritesReg,
    input  logic                 SetsFlags,
    input  logic                 IFNR_FLAG,
    input  logic                 INR_FLAG,
    input  logic                 MFC,
    output logic                 PC_Enable,
    output logic                 PC_Select,
    output logic                 INC_Select,
    output logic                 IR_Enable,
    output logic                 RA_Enable,
    output logic                 RB_Enable,
    output logic                 RZ_Enable,
    output logic                 RM_Enable,
    output logic                 RY_Enable,
    output logic                 RY_Select,
    output logic                 RF_WRITE,
    output logic                 CCR_Enable,
    output logic                 MEM_Read,
    output logic                 MEM_Write,
    output logic [2:0]           Stage,
    output logic                 Fault,
    output logic [CNT_WIDTH-1:0] Retired
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        FAULT     = 3'd7
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MFC_TIMEOUT - 1);

    state_t     state, next_state;
    logic       step_flag, step_flag_next;
    logic [7:0] wait_cnt;
    logic       mem_op;

    assign mem_op = IsLoad | IsStore;

    always_ff @(posedge Clock) begin
        if (ProcessorReset) begin
            state     <= IDLE;
            step_flag <= 1'b0;
            wait_cnt  <= '0;
            Retired   <= '0;
        end else begin
            state     <= next_state;
            step_flag <= step_flag_next;
            // Held at zero outside MEMORY, so it is already clear on entry
            if (state == MEMORY && mem_op && !MFC)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= '0;
            if (state == WRITEBACK)
                Retired <= Retired + 1'b1;
        end
    end

    always_comb begin
        next_state     = state;
        step_flag_next = step_flag;
        PC_Enable      = 1'b0;
        PC_Select      = 1'b1;
        INC_Select     = 1'b0;
        IR_Enable      = 1'b0;
        RA_Enable      = 1'b0;
        RB_Enable      = 1'b0;
        RZ_Enable      = 1'b0;
        RM_Enable      = 1'b0;
        RY_Enable      = 1'b0;
        RY_Select      = 1'b0;
        RF_WRITE       = 1'b0;
        CCR_Enable     = 1'b0;
        MEM_Read       = 1'b0;
        MEM_Write      = 1'b0;
        Fault          = 1'b0;

        case (state)
            IDLE: begin
                if (ProcessorEnable) begin
                    next_state = FETCH;
                end else if (Step) begin
                    next_state     = FETCH;
                    step_flag_next = 1'b1;
                end
            end
            FETCH: begin
                IR_Enable  = 1'b1;
                PC_Enable  = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                RA_Enable  = 1'b1;
                RB_Enable  = 1'b1;
                next_state = (IFNR_FLAG || INR_FLAG) ? FAULT : EXECUTE;
            end
            EXECUTE: begin
                RZ_Enable  = 1'b1;
                RM_Enable  = 1'b1;
                CCR_Enable = SetsFlags;
                if (IsJumpReg) begin
                    PC_Enable = 1'b1;
                    PC_Select = 1'b0;
                end else if (IsBranch && BranchTaken) begin
                    PC_Enable  = 1'b1;
                    INC_Select = 1'b1;
                end
                next_state = (IsLoad && IsStore) ? FAULT : MEMORY;
            end
            MEMORY: begin
                if (!mem_op) begin
                    RY_Enable  = 1'b1;
                    next_state = WRITEBACK;
                end else begin
                    MEM_Read  = IsLoad;
                    MEM_Write = IsStore;
                    if (MFC) begin
                        RY_Enable  = 1'b1;
                        RY_Select  = IsLoad;
                        next_state = WRITEBACK;
                    end else if (wait_cnt == WAIT_LAST) begin
                        next_state = FAULT;
                    end
                end
            end
            WRITEBACK: begin
                RF_WRITE = WritesReg & ~IsStore;
                if (ProcessorEnable && !step_flag) begin
                    next_state = FETCH;
                end else begin
                    next_state     = IDLE;
                    step_flag_next = 1'b0;
                end
            end
            FAULT: begin
                Fault = 1'b1;
            end
            default: begin
                next_state = FAULT;
            end
        endcase
    end

    assign Stage = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer: each instruction's cycle
// trace is predicted from its class and MFC delay, then compared cycle by cycle.
module tb_control_sequencer;

    localparam int unsigned TIMEOUT = 15;

    logic        Clock = 1'b0;
    logic        ProcessorReset, ProcessorEnable, Step;
    logic        IsLoad, IsStore, IsBranch, IsJumpReg, BranchTaken;
    logic        WritesReg, SetsFlags, IFNR_FLAG, INR_FLAG, MFC;
    logic        PC_Enable, PC_Select, INC_Select, IR_Enable, RA_Enable, RB_Enable;
    logic        RZ_Enable, RM_Enable, RY_Enable, RY_Select, RF_WRITE, CCR_Enable;
    logic        MEM_Read, MEM_Write, Fault;
    logic [2:0]  Stage;
    logic [31:0] Retired;
    logic [17:0] obs;

    int checks = 0;
    int fails  = 0;
    int unsigned retired_model = 0;

    typedef struct {
        bit ld, st, br, taken, jr, wr, fl;
        int k;
    } instr_t;

    always #5 Clock = ~Clock;

    control_sequencer #(.MFC_TIMEOUT(TIMEOUT), .CNT_WIDTH(32)) dut (
        .Clock(Clock), .ProcessorReset(ProcessorReset), .ProcessorEnable(ProcessorEnable),
        .Step(Step), .IsLoad(IsLoad), .IsStore(IsStore), .IsBranch(IsBranch),
        .IsJumpReg(IsJumpReg), .BranchTaken(BranchTaken), .WritesReg(WritesReg),
        .SetsFlags(SetsFlags), .IFNR_FLAG(IFNR_FLAG), .INR_FLAG(INR_FLAG), .MFC(MFC),
        .PC_Enable(PC_Enable), .PC_Select(PC_Select), .INC_Select(INC_Select),
        .IR_Enable(IR_Enable), .RA_Enable(RA_Enable), .RB_Enable(RB_Enable),
        .RZ_Enable(RZ_Enable), .RM_Enable(RM_Enable), .RY_Enable(RY_Enable),
        .RY_Select(RY_Select), .RF_WRITE(RF_WRITE), .CCR_Enable(CCR_Enable),
        .MEM_Read(MEM_Read), .MEM_Write(MEM_Write), .Stage(Stage), .Fault(Fault),
        .Retired(Retired)
    );

    assign obs = {Stage, Fault, PC_Enable, PC_Select, INC_Select, IR_Enable, RA_Enable,
                  RB_Enable, RZ_Enable, RM_Enable, RY_Enable, RY_Select, RF_WRITE,
                  CCR_Enable, MEM_Read, MEM_Write};

    // Expected output vector for a given stage of an instruction (same packing as obs)
    function automatic logic [17:0] expect_out(input int st, input instr_t in, input bit mfc);
        logic [2:0] s3;
        logic f, pce, pcs, inc, ir, ra, rb, rz, rm, rye, rys, rf, ccr, mr, mw;
        s3 = st[2:0];
        {pce, inc, ir, ra, rb, rz, rm, rye, rys, rf, ccr, mr, mw} = '0;
        pcs = 1'b1;
        f   = (st == 7);
        case (st)
            1: begin ir = 1; pce = 1; end
            2: begin ra = 1; rb = 1; end
            3: begin
                rz = 1; rm = 1; ccr = in.fl;
                if (in.jr) begin pce = 1; pcs = 0; end
                else if (in.br && in.taken) begin pce = 1; inc = 1; end
            end
            4: begin
                if (!(in.ld || in.st)) rye = 1;
                else begin
                    mr = in.ld; mw = in.st;
                    if (mfc) begin rye = 1; rys = in.ld; end
                end
            end
            5: rf = in.wr & ~in.st;
            default: ;
        endcase
        return {s3, f, pce, pcs, inc, ir, ra, rb, rz, rm, rye, rys, rf, ccr, mr, mw};
    endfunction

    function automatic instr_t mk(input int cls, input bit wr, input bit fl, input bit taken, input int k);
        instr_t in;
        in = '{default: 0};
        in.ld = (cls == 1); in.st = (cls == 2); in.br = (cls == 3); in.jr = (cls == 4);
        in.wr = wr; in.fl = fl; in.taken = taken; in.k = k;
        return in;
    endfunction

    function automatic int stage_at(input int c, input int len);
        if (c < 3) return c + 1;
        if (c == len - 1) return 5;
        return 4;
    endfunction

    task automatic drive_instr(input instr_t in);
        IsLoad = in.ld; IsStore = in.st; IsBranch = in.br; IsJumpReg = in.jr;
        BranchTaken = in.taken; WritesReg = in.wr; SetsFlags = in.fl;
    endtask

    task automatic test_reset();
        instr_t nop;
        nop = mk(0, 0, 0, 0, 0);
        ProcessorReset = 1; ProcessorEnable = 1; Step = 1; MFC = 1;
        IFNR_FLAG = 0; INR_FLAG = 0;
        drive_instr(mk(1, 1, 1, 1, 0));
        repeat (2) @(posedge Clock);
        #1;
        ProcessorEnable = 0; Step = 0; MFC = 0;
        drive_instr(nop);
        #1;
        checks++;
        if (obs !== expect_out(0, nop, 0)) begin
            fails++; $display("FAIL reset_outputs: got %b expected %b", obs, expect_out(0, nop, 0));
        end
        checks++;
        if (Retired !== 32'd0) begin
            fails++; $display("FAIL reset_retired: got %0d expected 0", Retired);
        end
        ProcessorReset = 0;
        retired_model = 0;
        @(posedge Clock); #1;
    endtask

    task automatic test_stream();
        instr_t prog[$];
        instr_t in;
        int len, st;
        bit mfc;
        repeat (3) prog.push_back(mk(0, 1, 1, 0, 0));
        prog.push_back(mk(1, 1, 0, 0, 3));
        prog.push_back(mk(2, 1, 0, 0, 3));
        prog.push_back(mk(3, 0, 0, 1, 0));
        prog.push_back(mk(4, 0, 0, 0, 0));
        prog.push_back(mk(3, 0, 0, 0, 0));
        prog.push_back(mk(1, 1, 1, 0, 0));
        for (int n = 0; n < 14; n++)
            prog.push_back(mk($urandom_range(0, 4), 1'($urandom), 1'($urandom),
                              1'($urandom), $urandom_range(0, 6)));

        ProcessorEnable = 1;
        #1;
        checks++;
        if (Stage !== 3'd0) begin
            fails++; $display("FAIL stream_idle: got stage %0d expected 0", Stage);
        end
        @(posedge Clock); #1;

        foreach (prog[i]) begin
            in = prog[i];
            drive_instr(in);
            len = (in.ld || in.st) ? 5 + in.k : 5;
            for (int c = 0; c < len; c++) begin
                st  = stage_at(c, len);
                mfc = (st == 4 && (in.ld || in.st)) ? (c - 3 == in.k) : 1'($urandom);
                MFC  = mfc;
                Step = 1'($urandom);
                if (i == prog.size() - 1 && st == 5) ProcessorEnable = 0;
                #1;
                checks++;
                if (obs !== expect_out(st, in, mfc)) begin
                    fails++;
                    $display("FAIL stream_cycle instr=%0d cyc=%0d: got %b expected %b",
                             i, c, obs, expect_out(st, in, mfc));
                end
                @(posedge Clock); #1;
            end
            retired_model++;
            checks++;
            if (Retired !== retired_model) begin
                fails++; $display("FAIL stream_retired instr=%0d: got %0d expected %0d", i, Retired, retired_model);
            end
        end
        Step = 0; MFC = 0;
        #1;
        checks++;
        if (Stage !== 3'd0) begin
            fails++; $display("FAIL stream_end_idle: got stage %0d expected 0", Stage);
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_timeout();
        instr_t in;
        in = mk(1, 1, 0, 0, 0);
        drive_instr(in);
        MFC = 0;
        ProcessorEnable = 1;
        @(posedge Clock); #1;
        for (int c = 0; c < 3 + int'(TIMEOUT); c++) begin
            #1;
            checks++;
            if (obs !== expect_out(stage_at(c, 100), in, 0)) begin
                fails++; $display("FAIL timeout_wait cyc=%0d: got %b expected %b",
                                  c, obs, expect_out(stage_at(c, 100), in, 0));
            end
            @(posedge Clock); #1;
        end
        for (int c = 0; c < 4; c++) begin
            Step = (c == 1); MFC = (c == 2);
            #1;
            checks++;
            if (obs !== expect_out(7, in, 0)) begin
                fails++; $display("FAIL timeout_fault cyc=%0d: got %b expected %b", c, obs, expect_out(7, in, 0));
            end
            @(posedge Clock); #1;
        end
        Step = 0; MFC = 0;
        ProcessorReset = 1; ProcessorEnable = 0;
        @(posedge Clock); #1;
        ProcessorReset = 0;
        retired_model = 0;
        #1;
        checks++;
        if (obs !== expect_out(0, in, 0) || Retired !== 32'd0) begin
            fails++; $display("FAIL timeout_reset: got %b retired %0d expected %b retired 0",
                              obs, Retired, expect_out(0, in, 0));
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_decode_fault();
        instr_t in;
        in = mk(0, 1, 1, 0, 0);
        for (int f = 0; f < 2; f++) begin
            drive_instr(in);
            IFNR_FLAG = (f == 0); INR_FLAG = (f == 1);
            ProcessorEnable = 1;
            @(posedge Clock); #1;
            for (int c = 0; c < 5; c++) begin
                #1;
                checks++;
                if (obs !== expect_out(c < 2 ? c + 1 : 7, in, 0) || Retired !== retired_model) begin
                    fails++; $display("FAIL decode_fault flag=%0d cyc=%0d: got %b retired %0d expected %b retired %0d",
                                      f, c, obs, Retired, expect_out(c < 2 ? c + 1 : 7, in, 0), retired_model);
                end
                @(posedge Clock); #1;
            end
            ProcessorReset = 1; ProcessorEnable = 0; IFNR_FLAG = 0; INR_FLAG = 0;
            @(posedge Clock); #1;
            ProcessorReset = 0;
            retired_model = 0;
        end
    endtask

    task automatic test_step();
        instr_t in;
        in = mk(0, 1, 0, 0, 0);
        drive_instr(in);
        ProcessorEnable = 0; Step = 0;
        for (int c = 0; c < 3; c++) begin
            Step = (c == 2);
            #1;
            checks++;
            if (obs !== expect_out(0, in, 0)) begin
                fails++; $display("FAIL step_idle cyc=%0d: got %b expected %b", c, obs, expect_out(0, in, 0));
            end
            @(posedge Clock); #1;
        end
        Step = 0;
        for (int c = 0; c < 5; c++) begin
            Step = (c == 2);
            #1;
            checks++;
            if (obs !== expect_out(c + 1, in, 0)) begin
                fails++; $display("FAIL step_run cyc=%0d: got %b expected %b", c, obs, expect_out(c + 1, in, 0));
            end
            @(posedge Clock); #1;
        end
        Step = 0;
        retired_model++;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (Stage !== 3'd0 || Retired !== retired_model) begin
                fails++; $display("FAIL step_after cyc=%0d: got stage %0d retired %0d expected stage 0 retired %0d",
                                  c, Stage, Retired, retired_model);
            end
            @(posedge Clock); #1;
        end
        ProcessorEnable = 1;
        @(posedge Clock); #1;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) ProcessorEnable = 0;
            #1;
            checks++;
            if (obs !== expect_out(c + 1, in, 0)) begin
                fails++; $display("FAIL drop_enable cyc=%0d: got %b expected %b", c, obs, expect_out(c + 1, in, 0));
            end
            @(posedge Clock); #1;
        end
        retired_model++;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (Stage !== 3'd0 || Retired !== retired_model) begin
                fails++; $display("FAIL drop_enable_idle cyc=%0d: got stage %0d retired %0d expected stage 0 retired %0d",
                                  c, Stage, Retired, retired_model);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_reset_mid_memory();
        instr_t in;
        in = mk(2, 0, 0, 0, 0);
        drive_instr(in);
        MFC = 0;
        ProcessorEnable = 1;
        @(posedge Clock); #1;
        repeat (4) begin @(posedge Clock); #1; end
        ProcessorReset = 1;
        #1;
        checks++;
        if (obs !== expect_out(4, in, 0)) begin
            fails++; $display("FAIL reset_mem_before: got %b expected %b", obs, expect_out(4, in, 0));
        end
        @(posedge Clock); #1;
        ProcessorReset = 0; ProcessorEnable = 0;
        retired_model = 0;
        #1;
        checks++;
        if (obs !== expect_out(0, in, 0) || Retired !== 32'd0) begin
            fails++; $display("FAIL reset_mem_after: got %b retired %0d expected %b retired 0",
                              obs, Retired, expect_out(0, in, 0));
        end
        @(posedge Clock); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_timeout();
        test_decode_fault();
        test_step();
        test_reset_mid_memory();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
